// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared definitions for the Sobel datapath: pixel width, window size,
//   the pixel type and the 3x3 window index constants that the window
//   generator and the gradient stages agree on.
//
//   Window layout (row-major):
//       TL TC TR      0 1 2
//       ML MC MR  =   3 4 5
//       BL BC BR      6 7 8
package sobel_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WIN_SIZE = 9;

    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int TL = 0;
    localparam int TC = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MC = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BC = 7;
    localparam int BR = 8;

    // Flat window index of (row, col) inside the 3x3 neighbourhood.
    function automatic int win_idx(input int row, input int col);
        return row * 3 + col;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
//   One image line of pixel storage. A single address is shared by the
//   read and the write port; the read is combinational, so in the cycle
//   a write is enabled rd_data still shows the old contents
//   (read-before-write). Contents are not reset.
//
// Ports
//   clk      in   clock, rising edge
//   addr     in   column address for both read and write
//   wr_en    in   write wr_data at addr on this edge
//   wr_data  in   pixel to store
//   rd_data  out  pixel currently stored at addr
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     wr_en,
    input  pixel_t                   wr_data,
    output pixel_t                   rd_data
);

    pixel_t mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_generator.sv
// window_generator
//   Turns a raster-order grayscale stream into 3x3 neighbourhoods for the
//   gradient stages. Line buffer A holds the previous line, line buffer B
//   the line before that. Every accepted pixel shifts the window left by
//   one column and inserts {B[c], A[c], pixel_in} as the new right column.
//   A window is strobed only when it lies wholly inside the image
//   (row >= 2 and col >= 2 of the pixel just accepted).
//
// Ports
//   clk                 in   clock, rising edge
//   rst                 in   synchronous active-high reset (wins over pixel_valid)
//   pixel_in            in   grayscale pixel
//   pixel_valid         in   pixel_in is accepted on this edge
//   frame_start         in   with pixel_valid: this pixel is (0,0)
//   windowBuffer[0:8]   out  registered 3x3 window, row-major
//   start_calculations  out  one-cycle strobe: windowBuffer holds a new window
//   frame_done          out  one-cycle strobe after the last pixel of a frame
module window_generator
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic   clk,
    input  logic   rst,
    input  pixel_t pixel_in,
    input  logic   pixel_valid,
    input  logic   frame_start,
    output pixel_t windowBuffer [0:8],
    output logic   start_calculations,
    output logic   frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    pixel_t           win_q [0:WIN_SIZE-1];
    pixel_t           win_d [0:WIN_SIZE-1];
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             at_last_col, at_last_row;
    logic             lb_wr_en;
    pixel_t           lb_a_rd, lb_b_rd;

    // frame_start forces the position of the current pixel to (0,0); this
    // also steers the line-buffer address so column 0 is read and written.
    always_comb begin
        cur_col     = frame_start ? '0 : col_q;
        cur_row     = frame_start ? '0 : row_q;
        at_last_col = (cur_col == COL_LAST);
        at_last_row = (cur_row == ROW_LAST);
    end

    // A dropped pixel (reset in the same cycle) must not touch the buffers.
    assign lb_wr_en = pixel_valid & ~rst;

    // A holds line r-1; its old value moves into B, which then holds r-2.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_line_a (
        .clk     (clk),
        .addr    (cur_col),
        .wr_en   (lb_wr_en),
        .wr_data (pixel_in),
        .rd_data (lb_a_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line_b (
        .clk     (clk),
        .addr    (cur_col),
        .wr_en   (lb_wr_en),
        .wr_data (lb_a_rd),
        .rd_data (lb_b_rd)
    );

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        start_d = 1'b0;
        done_d  = 1'b0;

        if (pixel_valid) begin
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            for (int i = 0; i < 3; i++) begin
                win_d[win_idx(i, 0)] = win_q[win_idx(i, 1)];
                win_d[win_idx(i, 1)] = win_q[win_idx(i, 2)];
            end
            win_d[TR] = lb_b_rd;
            win_d[MR] = lb_a_rd;
            win_d[BR] = pixel_in;

            // Columns 0 and 1 still carry the tail of the previous line.
            start_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            done_d  = at_last_row && at_last_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            start_q <= start_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign windowBuffer       = win_q;
    assign start_calculations = start_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator
//   Directed bench for window_generator on a 5x4 image (pixel = base +
//   10*row + col) plus a 3x3 all-255 image on a second instance.
module tb_window_generator;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pixel_in = '0;
    logic       pixel_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] windowBuffer [0:8];
    logic       start_calculations;
    logic       frame_done;

    logic [7:0] pixel_in2 = '0;
    logic       pixel_valid2 = 1'b0;
    logic       frame_start2 = 1'b0;
    logic [7:0] windowBuffer2 [0:8];
    logic       start_calculations2;
    logic       frame_done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk                (clk),
        .rst                (rst),
        .pixel_in           (pixel_in),
        .pixel_valid        (pixel_valid),
        .frame_start        (frame_start),
        .windowBuffer       (windowBuffer),
        .start_calculations (start_calculations),
        .frame_done         (frame_done)
    );

    window_generator #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_small (
        .clk                (clk),
        .rst                (rst),
        .pixel_in           (pixel_in2),
        .pixel_valid        (pixel_valid2),
        .frame_start        (frame_start2),
        .windowBuffer       (windowBuffer2),
        .start_calculations (start_calculations2),
        .frame_done         (frame_done2)
    );

    function automatic logic [7:0] exp_pix(input int base, input int r, input int c);
        return 8'(base + 10 * r + c);
    endfunction

    // Drive one cycle of inputs on the falling edge, let the rising edge
    // take them, then settle 1 time unit past the edge.
    task automatic step(input logic v, input logic [7:0] p, input logic fs);
        @(negedge clk);
        pixel_valid = v;
        pixel_in    = p;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    // Streams one full frame and checks every strobe, window and frame_done.
    // With gaps set, an idle cycle (frame_start high, pixel_valid low)
    // follows every pixel; outputs must hold and strobes stay low.
    task automatic run_frame(input int base, input bit gaps, input bit fs_first, input string tag);
        int  n_strobes;
        bit  exp_s;
        bit  exp_d;
        logic [7:0] ev;
        n_strobes = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, exp_pix(base, r, c), fs_first && r == 0 && c == 0);
                exp_s = (r >= 2) && (c >= 2);
                exp_d = (r == H - 1) && (c == W - 1);
                if (start_calculations) n_strobes++;
                checks++;
                if (start_calculations !== exp_s) begin
                    errors++;
                    $display("FAIL %s strobe at (%0d,%0d): got %b expected %b", tag, r, c, start_calculations, exp_s);
                end
                checks++;
                if (frame_done !== exp_d) begin
                    errors++;
                    $display("FAIL %s frame_done at (%0d,%0d): got %b expected %b", tag, r, c, frame_done, exp_d);
                end
                if (exp_s) begin
                    for (int k = 0; k < 9; k++) begin
                        ev = exp_pix(base, r - 2 + k / 3, c - 2 + k % 3);
                        checks++;
                        if (windowBuffer[k] !== ev) begin
                            errors++;
                            $display("FAIL %s window[%0d] at (%0d,%0d): got %0d expected %0d", tag, k, r, c, windowBuffer[k], ev);
                        end
                    end
                end
                if (gaps) begin
                    step(1'b0, 8'hEE, 1'b1);
                    checks++;
                    if (start_calculations !== 1'b0 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s gap strobes after (%0d,%0d): got start=%b done=%b expected 0 0", tag, r, c, start_calculations, frame_done);
                    end
                    if (exp_s) begin
                        for (int k = 0; k < 9; k++) begin
                            ev = exp_pix(base, r - 2 + k / 3, c - 2 + k % 3);
                            checks++;
                            if (windowBuffer[k] !== ev) begin
                                errors++;
                                $display("FAIL %s gap hold window[%0d] after (%0d,%0d): got %0d expected %0d", tag, k, r, c, windowBuffer[k], ev);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (n_strobes != (W - 2) * (H - 2)) begin
            errors++;
            $display("FAIL %s strobe count: got %0d expected %0d", tag, n_strobes, (W - 2) * (H - 2));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (windowBuffer[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset window[%0d]: got %0d expected 0", k, windowBuffer[k]);
            end
        end
        checks++;
        if (start_calculations !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset strobes: got start=%b done=%b expected 0 0", start_calculations, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(0, 1'b0, 1'b0, "full_frame");
    endtask

    task automatic test_gaps();
        run_frame(30, 1'b1, 1'b0, "gaps");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 1'b0, 1'b0, "b2b_frame1");
        run_frame(100, 1'b0, 1'b0, "b2b_frame2");
    endtask

    task automatic test_frame_start_abandon();
        // Partial frame up to (2,0); the pixel that would be (2,1) restarts.
        for (int i = 0; i < 2 * W + 1; i++) begin
            step(1'b1, exp_pix(0, i / W, i % W), 1'b0);
            checks++;
            if (start_calculations !== 1'b0) begin
                errors++;
                $display("FAIL abandon partial strobe at pixel %0d: got %b expected 0", i, start_calculations);
            end
        end
        run_frame(50, 1'b0, 1'b1, "frame_start");
    endtask

    task automatic test_reset_mid_frame();
        // Pixels (0,0) .. (2,3), then reset together with a valid pixel.
        for (int i = 0; i < 2 * W + 4; i++) begin
            step(1'b1, exp_pix(0, i / W, i % W), 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (windowBuffer[k] !== 8'd0) begin
                errors++;
                $display("FAIL mid reset window[%0d]: got %0d expected 0", k, windowBuffer[k]);
            end
        end
        checks++;
        if (start_calculations !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid reset strobes: got start=%b done=%b expected 0 0", start_calculations, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        pixel_valid = 1'b0;
        run_frame(20, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_small_image();
        int n_strobes;
        n_strobes = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pixel_valid2 = 1'b1;
            pixel_in2    = 8'd255;
            @(posedge clk);
            #1;
            if (start_calculations2) n_strobes++;
            if (i == 8) begin
                checks++;
                if (start_calculations2 !== 1'b1 || frame_done2 !== 1'b1) begin
                    errors++;
                    $display("FAIL small strobes at last pixel: got start=%b done=%b expected 1 1", start_calculations2, frame_done2);
                end
                for (int k = 0; k < 9; k++) begin
                    checks++;
                    if (windowBuffer2[k] !== 8'd255) begin
                        errors++;
                        $display("FAIL small window[%0d]: got %0d expected 255", k, windowBuffer2[k]);
                    end
                end
            end
        end
        @(negedge clk);
        pixel_valid2 = 1'b0;
        checks++;
        if (n_strobes != 1) begin
            errors++;
            $display("FAIL small strobe count: got %0d expected 1", n_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_frame_start_abandon();
        test_reset_mid_frame();
        test_small_image();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
